// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state encoding, R/W bit meaning, address width.
package i2c_pkg;

  localparam int ADDR_W = 7;
  localparam logic I2C_RW_READ = 1'b1;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    SUB       = 4'd3,
    SUB_ACK   = 4'd4,
    WDATA     = 4'd5,
    WDATA_ACK = 4'd6,
    RDATA     = 4'd7,
    RDATA_ACK = 4'd8
  } state_t;

endpackage

// File: rtl/i2c_target_if.sv
// Bus-side and local-side signals of the I2C target, plus the FSM state for observation.
interface i2c_target_if;
  import i2c_pkg::*;

  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  // Strobes are single-cycle, no backpressure: wr_addr/wr_data are valid only in the cycle
  // wr_stb=1; rd_data must be valid combinationally in the cycle rd_stb=1 for rd_addr.
  logic       wr_stb;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_stb;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;
  state_t     state;

  modport slave (
    input  scl_in, sda_in, rd_data,
    output sda_oe, wr_stb, wr_addr, wr_data, rd_stb, rd_addr, busy, state
  );

  modport master (
    output scl_in, sda_in, rd_data,
    input  sda_oe, wr_stb, wr_addr, wr_data, rd_stb, rd_addr, busy, state
  );

endinterface

// File: rtl/i2c_line_sync.sv
// Synchroniser for one open-drain line plus rise/fall detection on the synced samples.
module i2c_line_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_50,
  input  logic rst_n,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  // Reset to 1 so an idle (pulled-up) bus produces no edge when reset releases.
  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], line_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target: address match, sub-address pointer, byte writes out and byte reads in, auto-increment.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDRESS     = 7'h1F,
  parameter int                SYNC_STAGES = 2
) (
  input logic          clk_50,
  input logic          rst_n,
  i2c_target_if.slave  bus
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk_50(clk_50), .rst_n(rst_n), .line_i(bus.scl_in),
    .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk_50(clk_50), .rst_n(rst_n), .line_i(bus.sda_in),
    .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  // SCL must be high in both samples; an SDA edge coinciding with an SCL edge is not START/STOP.
  logic scl_steady_high, start_det, stop_det;
  assign scl_steady_high = scl_lvl & ~scl_rise;
  assign start_det       = sda_fall & scl_steady_high;
  assign stop_det        = sda_rise & scl_steady_high;

  state_t     state_q;
  logic [7:0] shift_q;
  logic [2:0] bit_cnt_q;
  logic       byte_done_q;
  logic [7:0] ptr_q;
  logic       rw_q;
  logic       master_ack_q;
  logic       sda_oe_q;
  logic       busy_q;
  logic       wr_stb_q;
  logic [7:0] wr_addr_q;
  logic [7:0] wr_data_q;
  logic       rd_stb_q;
  logic [7:0] rd_addr_q;

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      byte_done_q  <= 1'b0;
      ptr_q        <= '0;
      rw_q         <= 1'b0;
      master_ack_q <= 1'b0;
      sda_oe_q     <= 1'b0;
      busy_q       <= 1'b0;
      wr_stb_q     <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      rd_stb_q     <= 1'b0;
      rd_addr_q    <= '0;
    end else begin
      wr_stb_q <= 1'b0;
      rd_stb_q <= 1'b0;
      if (start_det) begin
        state_q     <= ADDR;
        bit_cnt_q   <= '0;
        byte_done_q <= 1'b0;
        sda_oe_q    <= 1'b0;
      end else if (stop_det) begin
        state_q     <= IDLE;
        bit_cnt_q   <= '0;
        byte_done_q <= 1'b0;
        sda_oe_q    <= 1'b0;
        busy_q      <= 1'b0;
      end else if (rd_stb_q) begin
        // Read byte is sampled in the strobe cycle, while SCL is still low after the fall.
        shift_q   <= bus.rd_data;
        sda_oe_q  <= ~bus.rd_data[7];
        bit_cnt_q <= '0;
      end else if (scl_rise) begin
        if (state_q == ADDR || state_q == SUB || state_q == WDATA) begin
          shift_q     <= {shift_q[6:0], sda_lvl};
          bit_cnt_q   <= bit_cnt_q + 3'd1;
          byte_done_q <= (bit_cnt_q == 3'd7);
        end
        if (state_q == RDATA_ACK) master_ack_q <= ~sda_lvl;
      end else if (scl_fall) begin
        case (state_q)
          ADDR: if (byte_done_q) begin
            byte_done_q <= 1'b0;
            rw_q        <= shift_q[0];
            if (shift_q[7:1] == ADDRESS) begin
              sda_oe_q <= 1'b1;
              busy_q   <= 1'b1;
              state_q  <= ADDR_ACK;
            end else begin
              state_q <= IDLE;
            end
          end
          ADDR_ACK: begin
            sda_oe_q <= 1'b0;
            if (rw_q == I2C_RW_READ) begin
              rd_stb_q  <= 1'b1;
              rd_addr_q <= ptr_q;
              state_q   <= RDATA;
            end else begin
              state_q <= SUB;
            end
          end
          SUB: if (byte_done_q) begin
            byte_done_q <= 1'b0;
            ptr_q       <= shift_q;
            sda_oe_q    <= 1'b1;
            state_q     <= SUB_ACK;
          end
          SUB_ACK, WDATA_ACK: begin
            sda_oe_q <= 1'b0;
            state_q  <= WDATA;
          end
          WDATA: if (byte_done_q) begin
            byte_done_q <= 1'b0;
            wr_stb_q    <= 1'b1;
            wr_addr_q   <= ptr_q;
            wr_data_q   <= shift_q;
            ptr_q       <= ptr_q + 8'd1;
            sda_oe_q    <= 1'b1;
            state_q     <= WDATA_ACK;
          end
          RDATA: begin
            if (bit_cnt_q == 3'd7) begin
              sda_oe_q  <= 1'b0;
              bit_cnt_q <= '0;
              state_q   <= RDATA_ACK;
            end else begin
              shift_q   <= {shift_q[6:0], 1'b0};
              sda_oe_q  <= ~shift_q[6];
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
          RDATA_ACK: begin
            ptr_q <= ptr_q + 8'd1;
            if (master_ack_q) begin
              rd_stb_q  <= 1'b1;
              rd_addr_q <= ptr_q + 8'd1;
              state_q   <= RDATA;
            end else begin
              sda_oe_q <= 1'b0;
              state_q  <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.sda_oe  = sda_oe_q;
  assign bus.busy    = busy_q;
  assign bus.wr_stb  = wr_stb_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.rd_stb  = rd_stb_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bit-banged I2C master driving i2c_target, with a strobe scoreboard and an SDA-glitch monitor.
module tb_i2c_target;
  import i2c_pkg::*;

  localparam int Q = 8;

  logic clk_50 = 1'b0;
  logic rst_n;
  logic scl_m, sda_m;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] exp_wr_q[$];
  logic [7:0]  exp_rd_q[$];

  i2c_target_if bus ();
  assign bus.scl_in  = scl_m;
  assign bus.sda_in  = sda_m & ~bus.sda_oe;
  assign bus.rd_data = bus.rd_addr ^ 8'hFF;

  i2c_target #(.ADDRESS(7'h1F), .SYNC_STAGES(2)) dut (
    .clk_50(clk_50),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Clock / reset
  always #10 clk_50 = ~clk_50;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic wait_q();
    repeat (Q) @(posedge clk_50);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
    wait_q();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; wait_q();
    scl_m = 1'b1; wait_q();
    wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    @(negedge clk_50);
    b = bus.sda_in;
    wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack_n);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack_n);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic master_ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(~master_ack);
  endtask

  // Scoreboard monitor
  logic oe_seen;
  logic oe_prev = 1'b0;
  logic scl_prev = 1'b1;

  always @(negedge clk_50) begin
    if (bus.wr_stb) begin
      n_vec++;
      if (exp_wr_q.size() == 0) begin
        n_err++;
        $display("FAIL wr_stb_unexpected: got addr %0h data %0h expected no strobe", bus.wr_addr, bus.wr_data);
      end else begin
        logic [15:0] e;
        e = exp_wr_q.pop_front();
        if ({bus.wr_addr, bus.wr_data} !== e) begin
          n_err++;
          $display("FAIL wr_stb: got %0h expected %0h", {bus.wr_addr, bus.wr_data}, e);
        end
      end
    end
    if (bus.rd_stb) begin
      n_vec++;
      if (exp_rd_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_stb_unexpected: got addr %0h expected no strobe", bus.rd_addr);
      end else begin
        logic [7:0] e;
        e = exp_rd_q.pop_front();
        if (bus.rd_addr !== e) begin
          n_err++;
          $display("FAIL rd_addr: got %0h expected %0h", bus.rd_addr, e);
        end
      end
    end
    if (bus.sda_oe) oe_seen = 1'b1;
    if (rst_n && scl_m && scl_prev && (bus.sda_oe !== oe_prev)) begin
      n_vec++;
      n_err++;
      $display("FAIL sda_oe_glitch: got change to %0b while SCL high expected no change", bus.sda_oe);
    end
    oe_prev  = bus.sda_oe;
    scl_prev = scl_m;
  end

  initial begin
    repeat (60000) @(posedge clk_50);
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    logic       ack;
    logic [7:0] rb;

    rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; oe_seen = 1'b0;
    repeat (4) @(posedge clk_50);
    @(negedge clk_50);
    check("rst_sda_oe",  32'(bus.sda_oe), 32'h0);
    check("rst_busy",    32'(bus.busy), 32'h0);
    check("rst_strobes", 32'({bus.wr_stb, bus.rd_stb}), 32'h0);
    check("rst_regs",    32'({bus.wr_addr, bus.wr_data, bus.rd_addr}), 32'h0);
    check("rst_state",   32'(bus.state), 32'(IDLE));
    rst_n = 1'b1;
    wait_q();

    // Write: sub 0xCC, data 0x2A, 0xEC
    exp_wr_q.push_back({8'hCC, 8'h2A});
    exp_wr_q.push_back({8'hCD, 8'hEC});
    i2c_start();
    write_byte(8'h3E, ack); check("wr_addr_ack", 32'(ack), 32'h0);
    check("wr_busy", 32'(bus.busy), 32'h1);
    write_byte(8'hCC, ack); check("wr_sub_ack", 32'(ack), 32'h0);
    write_byte(8'h2A, ack); check("wr_d0_ack", 32'(ack), 32'h0);
    write_byte(8'hEC, ack); check("wr_d1_ack", 32'(ack), 32'h0);
    i2c_stop();
    check("wr_busy_after_stop", 32'(bus.busy), 32'h0);
    check("wr_idle_after_stop", 32'(bus.state), 32'(IDLE));

    // Read: sub 0x10, Sr, ACK first byte, NACK second
    exp_rd_q.push_back(8'h10);
    exp_rd_q.push_back(8'h11);
    i2c_start();
    write_byte(8'h3E, ack); check("rd_addrw_ack", 32'(ack), 32'h0);
    write_byte(8'h10, ack); check("rd_sub_ack", 32'(ack), 32'h0);
    i2c_rstart();
    write_byte(8'h3F, ack); check("rd_addrr_ack", 32'(ack), 32'h0);
    read_byte(rb, 1'b1); check("rd_byte0", 32'(rb), 32'hEF);
    read_byte(rb, 1'b0); check("rd_byte1", 32'(rb), 32'hEE);
    i2c_stop();
    check("rd_busy_after_stop", 32'(bus.busy), 32'h0);

    // Address mismatch
    oe_seen = 1'b0;
    i2c_start();
    write_byte(8'h40, ack); check("mm_addr_nack", 32'(ack), 32'h1);
    check("mm_busy", 32'(bus.busy), 32'h0);
    write_byte(8'h55, ack); check("mm_data_nack", 32'(ack), 32'h1);
    i2c_stop();
    check("mm_oe_never", 32'(oe_seen), 32'h0);

    // Pointer wrap
    exp_wr_q.push_back({8'hFF, 8'h01});
    exp_wr_q.push_back({8'h00, 8'h02});
    i2c_start();
    write_byte(8'h3E, ack); check("wrap_addr_ack", 32'(ack), 32'h0);
    write_byte(8'hFF, ack); check("wrap_sub_ack", 32'(ack), 32'h0);
    write_byte(8'h01, ack); check("wrap_d0_ack", 32'(ack), 32'h0);
    write_byte(8'h02, ack); check("wrap_d1_ack", 32'(ack), 32'h0);
    i2c_stop();

    // STOP after 4 data bits: partial byte dropped
    i2c_start();
    write_byte(8'h3E, ack); check("abort_addr_ack", 32'(ack), 32'h0);
    write_byte(8'h20, ack); check("abort_sub_ack", 32'(ack), 32'h0);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    i2c_stop();
    check("abort_idle", 32'(bus.state), 32'(IDLE));
    check("abort_busy", 32'(bus.busy), 32'h0);

    // Reset asserted while the address ACK is being driven
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(1'(8'h3E >> i));
    check("rstack_oe_before", 32'(bus.sda_oe), 32'h1);
    @(negedge clk_50);
    rst_n = 1'b0;
    #1;
    check("rstack_oe_released", 32'(bus.sda_oe), 32'h0);
    repeat (3) @(negedge clk_50);
    rst_n = 1'b1;
    check("rstack_state", 32'(bus.state), 32'(IDLE));
    check("rstack_busy", 32'(bus.busy), 32'h0);
    i2c_stop();

    check("exp_wr_drained", 32'(exp_wr_q.size()), 32'h0);
    check("exp_rd_drained", 32'(exp_rd_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
